mult_sequencer: RTL

Control sequencer for the shift-add multiplier datapath of the practice board. It captures operand A and then operand B on successive presses of inputdata_ready, clears the accumulator, and steps the datapath through WIDTH shift/add iterations. It then holds done until the next press starts a new operation. It sits between the input-capture front end and the multiplier registers, and replaces ad-hoc load gating.

---
 rtl/mult_sequencer_if.sv | 71 +++++++
 rtl/mult_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_sequencer_if
//
// Purpose: groups the handshake between the shift-add multiplier sequencer and
// the surrounding front end / datapath into one bundle.
//
// Optional feature macro: MULTSEQ_EARLY_EXIT_EN (adds b_zero).
//
// Signals:
//   inputdata_ready  front end -> sequencer, operand-ready level (clk domain)
//   lsb_b            datapath  -> sequencer, LSB of the shifting B register
//   b_zero           datapath  -> sequencer, B register is all zeros
//                    (only with MULTSEQ_EARLY_EXIT_EN)
//   load_a           sequencer -> datapath, one-cycle pulse, latch operand A
//   load_b           sequencer -> datapath, one-cycle pulse, latch operand B
//   clr_acc          sequencer -> datapath, one-cycle pulse, clear accumulator
//   add_en           sequencer -> datapath, accumulate shifted A this cycle
//   shift_en         sequencer -> datapath, shift A left / B right this cycle
//   busy             sequencer status, clearing or iterating
//   done             sequencer status, result valid
//
// Modports:
//   master  the sequencer side (drives the strobes and status)
//   slave   the front end / datapath side
// -----------------------------------------------------------------------------
interface mult_sequencer_if;

   logic inputdata_ready;
   logic lsb_b;
`ifdef MULTSEQ_EARLY_EXIT_EN
   logic b_zero;
`endif
   logic load_a;
   logic load_b;
   logic clr_acc;
   logic add_en;
   logic shift_en;
   logic busy;
   logic done;

   modport master (
`ifdef MULTSEQ_EARLY_EXIT_EN
      input  b_zero,
`endif
      input  inputdata_ready,
      input  lsb_b,
      output load_a,
      output load_b,
      output clr_acc,
      output add_en,
      output shift_en,
      output busy,
      output done
   );

   modport slave (
`ifdef MULTSEQ_EARLY_EXIT_EN
      output b_zero,
`endif
      output inputdata_ready,
      output lsb_b,
      input  load_a,
      input  load_b,
      input  clr_acc,
      input  add_en,
      input  shift_en,
      input  busy,
      input  done
   );

endinterface

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//
// Purpose: control sequencer for a shift-add multiplier datapath. Operand A is
// captured on one rising edge of inputdata_ready, operand B on the next; the
// accumulator is then cleared and the datapath is stepped through WIDTH
// shift/add iterations. done is held until the next rising edge of
// inputdata_ready, which immediately starts capturing a new operand A.
//
// Optional feature macro: MULTSEQ_EARLY_EXIT_EN
//   When defined, the interface carries b_zero and the iteration phase ends as
//   soon as b_zero is seen high (that cycle neither shifts nor adds).
//
// Parameters:
//   WIDTH  operand width and iteration count (2..32)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active high; forces IDLE and drops all outputs
//   bus    mult_sequencer_if.master
//            in : inputdata_ready, lsb_b, [b_zero]
//            out: load_a, load_b, clr_acc, add_en, shift_en, busy, done
// -----------------------------------------------------------------------------
module mult_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   mult_sequencer_if.master   bus
);

   // Iteration counter width, derived from WIDTH only.
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLda   = 3'd1,
      StWaitB = 3'd2,
      StLdb   = 3'd3,
      StClr   = 3'd4,
      StRun   = 3'd5,
      StDone  = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prev_rdy_q;
   logic             rise;

   logic             load_a;
   logic             load_b;
   logic             clr_acc;
   logic             add_en;
   logic             shift_en;
   logic             busy;
   logic             done;

   // Single-cycle rise of the operand-ready level; holding it high yields one.
   assign rise = bus.inputdata_ready & ~prev_rdy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         prev_rdy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_rdy_q <= bus.inputdata_ready;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_a   = 1'b0;
      load_b   = 1'b0;
      clr_acc  = 1'b0;
      add_en   = 1'b0;
      shift_en = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         StIdle: begin
            if (rise) state_d = StLda;
         end

         StLda: begin
            load_a  = 1'b1;
            state_d = StWaitB;
         end

         StWaitB: begin
            if (rise) state_d = StLdb;
         end

         StLdb: begin
            load_b  = 1'b1;
            state_d = StClr;
         end

         StClr: begin
            clr_acc = 1'b1;
            busy    = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
         end

         StRun: begin
            busy = 1'b1;
`ifdef MULTSEQ_EARLY_EXIT_EN
            // Nothing left to add once B is empty: skip straight to DONE.
            if (bus.b_zero) begin
               state_d = StDone;
            end else begin
               shift_en = 1'b1;
               add_en   = bus.lsb_b;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LastIter) state_d = StDone;
            end
`else
            shift_en = 1'b1;
            // Mealy path: add decision follows the live B LSB.
            add_en   = bus.lsb_b;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LastIter) state_d = StDone;
`endif
         end

         StDone: begin
            done = 1'b1;
            // A new press restarts directly with operand A, no IDLE visit.
            if (rise) state_d = StLda;
         end

         default: begin
            // Unused encoding: recover on the next clock.
            state_d = StIdle;
         end
      endcase
   end

   assign bus.load_a   = load_a;
   assign bus.load_b   = load_b;
   assign bus.clr_acc  = clr_acc;
   assign bus.add_en   = add_en;
   assign bus.shift_en = shift_en;
   assign bus.busy     = busy;
   assign bus.done     = done;

endmodule
